// File: rtl/dma_copy.sv
// Register-programmed word copy engine: a slave port for the control registers
// and a master port that moves LEN words from SRC to DST, one read/write pair at a time.
module dma_copy #(
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] data_o,
  output logic [31:0] mst_addr_o,
  output logic [31:0] mst_data_o,
  output logic [3:0]  mst_sel_o,
  output logic        mst_we_o,
  output logic        mst_req_valid_o,
  input  logic        mst_req_ready_i,
  input  logic        mst_rsp_valid_i,
  output logic        mst_rsp_ready_o,
  input  logic [31:0] mst_data_i,
  output logic        int_sig_o
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_REQ = 3'd1;
  localparam logic [2:0] S_RD_RSP = 3'd2;
  localparam logic [2:0] S_WR_REQ = 3'd3;
  localparam logic [2:0] S_WR_RSP = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_SRC    = 8'h08;
  localparam logic [7:0] A_DST    = 8'h0C;
  localparam logic [7:0] A_LEN    = 8'h10;

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d;
  logic [DW-1:0]    cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [DW-1:0]    buf_q, buf_d;
  logic             ie_q, ie_d, busy_q, busy_d, done_q, done_d;
  logic             req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [DW-1:0]    mst_addr_q, mst_addr_d, mst_data_q, mst_data_d;
  logic             mst_we_q, mst_we_d, mst_req_valid_q, mst_req_valid_d;
  logic             mst_rsp_ready_q, mst_rsp_ready_d, int_q, int_d;
  logic             req_fire_c, wr_fire_c, start_c;
  logic [7:0]       reg_addr_c;
  logic             unused_c;

  assign unused_c = ^{sel_i, addr_i[31:8]};

  // State and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      src_q           <= '0;
      dst_q           <= '0;
      len_q           <= '0;
      rem_q           <= '0;
      cur_src_q       <= '0;
      cur_dst_q       <= '0;
      buf_q           <= '0;
      ie_q            <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rdata_q         <= '0;
      mst_addr_q      <= '0;
      mst_data_q      <= '0;
      mst_we_q        <= 1'b0;
      mst_req_valid_q <= 1'b0;
      mst_rsp_ready_q <= 1'b0;
      int_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      src_q           <= src_d;
      dst_q           <= dst_d;
      len_q           <= len_d;
      rem_q           <= rem_d;
      cur_src_q       <= cur_src_d;
      cur_dst_q       <= cur_dst_d;
      buf_q           <= buf_d;
      ie_q            <= ie_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rdata_q         <= rdata_d;
      mst_addr_q      <= mst_addr_d;
      mst_data_q      <= mst_data_d;
      mst_we_q        <= mst_we_d;
      mst_req_valid_q <= mst_req_valid_d;
      mst_rsp_ready_q <= mst_rsp_ready_d;
      int_q           <= int_d;
    end
  end

  // Slave decode, FSM next state, and next values of all registered outputs
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    rem_d       = rem_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    buf_d       = buf_q;
    ie_d        = ie_q;
    busy_d      = busy_q;
    done_d      = done_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;

    reg_addr_c = addr_i[7:0];
    req_fire_c = req_valid_i & req_ready_q;
    wr_fire_c  = req_fire_c & we_i;
    start_c    = wr_fire_c && (reg_addr_c == A_CTRL) && data_i[0] && !busy_q
                 && (state_q == S_IDLE);

    if (req_fire_c) begin
      rsp_valid_d = 1'b1;
      req_ready_d = 1'b0;
      rdata_d     = '0;
      if (!we_i) begin
        case (reg_addr_c)
          A_CTRL:   rdata_d = {30'd0, ie_q, 1'b0};
          A_STATUS: rdata_d = {30'd0, done_q, busy_q};
          A_SRC:    rdata_d = src_q;
          A_DST:    rdata_d = dst_q;
          A_LEN:    rdata_d = DW'(len_q);
          default:  rdata_d = '0;
        endcase
      end
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
      req_ready_d = 1'b1;
      rdata_d     = '0;
    end

    // Address/length registers are frozen while a transfer owns them
    if (wr_fire_c) begin
      case (reg_addr_c)
        A_CTRL:   ie_d = data_i[1];
        A_STATUS: if (data_i[1]) done_d = 1'b0;
        A_SRC:    if (!busy_q) src_d = data_i;
        A_DST:    if (!busy_q) dst_d = data_i;
        A_LEN:    if (!busy_q) len_d = data_i[LEN_W-1:0];
        default:  ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          if (len_q != '0) begin
            cur_src_d = src_q;
            cur_dst_d = dst_q;
            rem_d     = len_q;
            busy_d    = 1'b1;
            state_d   = S_RD_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD_REQ: if (mst_req_ready_i) state_d = S_RD_RSP;
      S_RD_RSP: begin
        if (mst_rsp_valid_i) begin
          buf_d   = mst_data_i;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: if (mst_req_ready_i) state_d = S_WR_RSP;
      S_WR_RSP: begin
        if (mst_rsp_valid_i) begin
          cur_src_d = cur_src_q + 32'd4;
          cur_dst_d = cur_dst_q + 32'd4;
          rem_d     = rem_q - LEN_W'(1);
          state_d   = (rem_q > LEN_W'(1)) ? S_RD_REQ : S_DONE;
        end
      end
      S_DONE: begin
        // Completion set is applied after the W1C decode so it takes priority
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    mst_req_valid_d = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    mst_we_d        = (state_d == S_WR_REQ);
    mst_rsp_ready_d = (state_d == S_RD_RSP) || (state_d == S_WR_RSP);
    mst_addr_d      = (state_d == S_RD_REQ) ? cur_src_d :
                      (state_d == S_WR_REQ) ? cur_dst_d : '0;
    mst_data_d      = (state_d == S_WR_REQ) ? buf_d : '0;
    int_d           = done_d & ie_d;
  end

  assign req_ready_o     = req_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign data_o          = rdata_q;
  assign mst_addr_o      = mst_addr_q;
  assign mst_data_o      = mst_data_q;
  assign mst_sel_o       = 4'hF;
  assign mst_we_o        = mst_we_q;
  assign mst_req_valid_o = mst_req_valid_q;
  assign mst_rsp_ready_o = mst_rsp_ready_q;
  assign int_sig_o       = int_q;

endmodule
